// File: rtl/fifo_rd_stream.sv
// Async-FIFO read-side stream stage: credit-limited RAM prefetch into a circular buffer; m_valid
// RD_LATENCY+1 edges after the first rinc, 1 word/cycle; rinc stops once buffer+in-flight would overflow.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 2,
  localparam int LVL_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  rclk,
  input  logic                  rst_n,
  input  logic                  prefetch_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  rinc,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [LVL_W-1:0]      level
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + RD_LATENCY + 2);

  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [CNT_W-1:0]      inflight, outstanding;
  logic                  pop, wr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int k = 0; k < RD_LATENCY; k++) inflight = inflight + CNT_W'(pipe_q[k]);
  end

  assign m_valid     = (level_q != '0);
  assign m_data      = mem_q[head_q];
  assign level       = level_q;
  assign pop         = m_valid & m_ready;
  assign wr          = pipe_q[RD_LATENCY-1];
  assign outstanding = CNT_W'(level_q) + inflight;

  // A word leaving the buffer this cycle frees its slot for a same-cycle pop request.
  assign rinc = rst_n & prefetch_en & ~fifo_empty &
                (outstanding < (CNT_W'(BUF_DEPTH) + CNT_W'(pop)));

  always_comb begin
    pipe_d[0] = rinc;
    for (int k = 1; k < RD_LATENCY; k++) pipe_d[k] = pipe_q[k-1];
    head_d  = pop ? ptr_inc(head_q) : head_q;
    tail_d  = wr  ? ptr_inc(tail_q) : tail_q;
    level_d = level_q + LVL_W'(wr) - LVL_W'(pop);
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      for (int k = 0; k < BUF_DEPTH; k++) mem_q[k] <= '0;
    end else begin
      pipe_q  <= pipe_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      if (wr) mem_q[tail_q] <= fifo_rdata;
    end
  end

  // The credit rule must keep landing words from ever hitting a full, stalled buffer.
  a_no_overflow: assert property (@(posedge rclk) disable iff (!rst_n)
    !(wr && (level_q == LVL_W'(BUF_DEPTH)) && !pop));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: instance a (latency 1, depth 2) and b (latency 2, depth 3) driven by a
// modelled FIFO source; outputs checked against a timestamp/counter reference and a vector table.
module tb_fifo_rd_stream;

  logic rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic       rst_n [2];
  logic       prefetch_en [2];
  logic       fifo_empty [2];
  logic       rinc [2];
  logic       m_valid [2];
  logic       m_ready [2];
  logic [7:0] fifo_rdata [2];
  logic [7:0] m_data [2];
  logic [1:0] lvl_a;
  logic [2:0] lvl_b;

  fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(1), .BUF_DEPTH(2)) dut_a (
    .rclk(rclk), .rst_n(rst_n[0]), .prefetch_en(prefetch_en[0]), .fifo_empty(fifo_empty[0]),
    .fifo_rdata(fifo_rdata[0]), .rinc(rinc[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .m_data(m_data[0]), .level(lvl_a));

  fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(2), .BUF_DEPTH(3)) dut_b (
    .rclk(rclk), .rst_n(rst_n[1]), .prefetch_en(prefetch_en[1]), .fifo_empty(fifo_empty[1]),
    .fifo_rdata(fifo_rdata[1]), .rinc(rinc[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .m_data(m_data[1]), .level(lvl_b));

  int lat [2] = '{1, 2};
  int dep [2] = '{2, 3};
  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents, pop timestamps and running counters per instance.
  logic [7:0] src_mem [2][256];
  int         pop_cyc [2][256];
  int         n_loaded [2], n_popped [2], n_landed [2], n_consumed [2], cyc [2];
  logic [7:0] rdp [2][3];
  logic       gate [2];
  bit         act_rinc [2], act_pop [2];

  typedef struct {
    int         load;
    bit         rdy;
    bit         rinc;
    bit         vld;
    logic [7:0] dat;
    int         lvl;
  } vec_t;
  vec_t tbl [17];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lvl_of(input int i);
    return (i == 0) ? int'(lvl_a) : int'(lvl_b);
  endfunction

  task automatic sample();
    @(negedge rclk);
    for (int i = 0; i < 2; i++) begin
      int el;
      int er;
      int pe;
      if (rst_n[i]) begin
        el = n_landed[i] - n_consumed[i];
        chk($sformatf("level%0d", i), lvl_of(i), el);
        chk($sformatf("level_bound%0d", i), int'(lvl_of(i) <= dep[i]), 1);
        chk($sformatf("m_valid%0d", i), int'(m_valid[i]), int'(el != 0));
        if (el != 0 && n_consumed[i] < 256)
          chk($sformatf("m_data%0d", i), int'(m_data[i]), int'(src_mem[i][n_consumed[i]]));
        pe = (el != 0 && m_ready[i]) ? 1 : 0;
        er = (prefetch_en[i] && !fifo_empty[i] &&
              (n_popped[i] - n_consumed[i] - pe < dep[i])) ? 1 : 0;
        chk($sformatf("rinc%0d", i), int'(rinc[i]), er);
        act_rinc[i] = rinc[i];
        act_pop[i]  = m_valid[i] & m_ready[i];
      end else begin
        act_rinc[i] = 1'b0;
        act_pop[i]  = 1'b0;
      end
    end
  endtask

  task automatic advance();
    @(posedge rclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst_n[i]) begin
        cyc[i]++;
        if (act_pop[i]) n_consumed[i]++;
        for (int k = 2; k > 0; k--) rdp[i][k] = rdp[i][k-1];
        rdp[i][0] = 8'($urandom);
        if (act_rinc[i]) begin
          if (n_popped[i] < n_loaded[i]) begin
            pop_cyc[i][n_popped[i]] = cyc[i] - 1;
            rdp[i][0] = src_mem[i][n_popped[i]];
            n_popped[i]++;
          end else begin
            chk($sformatf("pop_past_end%0d", i), n_popped[i], n_loaded[i] - 1);
          end
        end
        fifo_rdata[i] = rdp[i][lat[i]-1];
        while (n_landed[i] < n_popped[i] && pop_cyc[i][n_landed[i]] + lat[i] + 1 <= cyc[i])
          n_landed[i]++;
        fifo_empty[i] = (n_popped[i] == n_loaded[i]) || gate[i];
      end
    end
  endtask

  // Reset one instance (checking outputs clear immediately), then refill its source FIFO.
  task automatic reset_and_load(input int i, input int n, input logic [7:0] base,
                                input logic [7:0] step, input bit rnd);
    rst_n[i] = 1'b0;
    #1;
    chk($sformatf("rst_level%0d", i), lvl_of(i), 0);
    chk($sformatf("rst_valid%0d", i), int'(m_valid[i]), 0);
    chk($sformatf("rst_rinc%0d", i), int'(rinc[i]), 0);
    chk($sformatf("rst_data%0d", i), int'(m_data[i]), 0);
    prefetch_en[i] = 1'b0;
    m_ready[i]     = 1'b0;
    gate[i]        = 1'b0;
    n_popped[i] = 0; n_landed[i] = 0; n_consumed[i] = 0; cyc[i] = 0;
    for (int k = 0; k < 3; k++) rdp[i][k] = 8'($urandom);
    for (int k = 0; k < n; k++)
      src_mem[i][k] = rnd ? 8'($urandom) : 8'(base + 8'(k) * step);
    n_loaded[i]   = n;
    fifo_empty[i] = (n == 0);
    fifo_rdata[i] = 8'($urandom);
    @(posedge rclk);
    #1;
    @(posedge rclk);
    #1;
    rst_n[i] = 1'b1;
  endtask

  task automatic run_random(input bit toggle_empty, input bit rand_pf);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 800 && !done; c++) begin
      for (int i = 0; i < 2; i++) begin
        m_ready[i]     = 1'($urandom_range(0, 1));
        prefetch_en[i] = rand_pf ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      sample();
      if (toggle_empty) for (int i = 0; i < 2; i++) gate[i] = ~gate[i];
      advance();
      done = (n_consumed[0] == n_loaded[0]) && (n_consumed[1] == n_loaded[1]);
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rand_count%0d", i), n_consumed[i], n_loaded[i]);
      gate[i] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    tbl[0]  = '{3, 1'b1, 1'b1, 1'b0, 8'h00, 0};
    tbl[1]  = '{0, 1'b1, 1'b1, 1'b0, 8'h00, 0};
    tbl[2]  = '{0, 1'b1, 1'b1, 1'b1, 8'h11, 1};
    tbl[3]  = '{0, 1'b1, 1'b0, 1'b1, 8'h22, 1};
    tbl[4]  = '{0, 1'b1, 1'b0, 1'b1, 8'h33, 1};
    tbl[5]  = '{0, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    tbl[6]  = '{5, 1'b0, 1'b1, 1'b0, 8'h00, 0};
    tbl[7]  = '{0, 1'b0, 1'b1, 1'b0, 8'h00, 0};
    tbl[8]  = '{0, 1'b0, 1'b0, 1'b1, 8'h11, 1};
    tbl[9]  = '{0, 1'b0, 1'b0, 1'b1, 8'h11, 2};
    tbl[10] = '{0, 1'b0, 1'b0, 1'b1, 8'h11, 2};
    tbl[11] = '{0, 1'b1, 1'b1, 1'b1, 8'h11, 2};
    tbl[12] = '{0, 1'b1, 1'b1, 1'b1, 8'h22, 1};
    tbl[13] = '{0, 1'b1, 1'b1, 1'b1, 8'h33, 1};
    tbl[14] = '{0, 1'b1, 1'b0, 1'b1, 8'h44, 1};
    tbl[15] = '{0, 1'b1, 1'b0, 1'b1, 8'h55, 1};
    tbl[16] = '{0, 1'b1, 1'b0, 1'b0, 8'h00, 0};

    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; prefetch_en[i] = 1'b1; fifo_empty[i] = 1'b1;
      m_ready[i] = 1'b0; fifo_rdata[i] = 8'h00; gate[i] = 1'b0;
      n_loaded[i] = 0; n_popped[i] = 0; n_landed[i] = 0; n_consumed[i] = 0; cyc[i] = 0;
      act_rinc[i] = 1'b0; act_pop[i] = 1'b0;
    end
    #1;
    reset_and_load(1, 0, 8'h00, 8'h00, 1'b0);

    // Directed vectors on instance a: three-word stream, then stall/fill and drain.
    for (int r = 0; r < 17; r++) begin
      if (tbl[r].load > 0) reset_and_load(0, tbl[r].load, 8'h11, 8'h11, 1'b0);
      prefetch_en[0] = 1'b1;
      m_ready[0]     = tbl[r].rdy;
      sample();
      chk($sformatf("vec%0d_rinc", r), int'(rinc[0]), int'(tbl[r].rinc));
      chk($sformatf("vec%0d_valid", r), int'(m_valid[0]), int'(tbl[r].vld));
      chk($sformatf("vec%0d_level", r), int'(lvl_a), tbl[r].lvl);
      if (tbl[r].vld) chk($sformatf("vec%0d_data", r), int'(m_data[0]), int'(tbl[r].dat));
      advance();
    end

    // Randomized traffic on both instances: flickering empty flag, then gated prefetch.
    reset_and_load(0, 40, 8'h00, 8'h00, 1'b1);
    reset_and_load(1, 40, 8'h00, 8'h00, 1'b1);
    run_random(1'b1, 1'b0);
    reset_and_load(0, 60, 8'h00, 8'h00, 1'b1);
    reset_and_load(1, 60, 8'h00, 8'h00, 1'b1);
    run_random(1'b0, 1'b1);

    // Instance b: first word after 3 edges, then one word per cycle.
    reset_and_load(1, 30, 8'h40, 8'h01, 1'b0);
    for (int c = 0; c < 15; c++) begin
      prefetch_en[1] = 1'b1;
      m_ready[1]     = 1'b1;
      sample();
      chk($sformatf("lat_valid_c%0d", c), int'(m_valid[1]), (c >= 3) ? 1 : 0);
      advance();
    end
    chk("lat_throughput", n_consumed[1], 12);

    // Reset with two buffered words and one read in flight; the in-flight word must vanish.
    reset_and_load(1, 8, 8'h60, 8'h01, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      prefetch_en[1] = 1'b1;
      m_ready[1]     = 1'b0;
      sample();
      if (n_landed[1] - n_consumed[1] == 2 && n_popped[1] - n_landed[1] == 1) found = 1'b1;
      else advance();
    end
    chk("mid_reset_reached", int'(found), 1);
    chk("pre_reset_level", int'(lvl_b), 2);
    reset_and_load(1, 4, 8'hA0, 8'h01, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      prefetch_en[1] = 1'b1;
      m_ready[1]     = 1'b1;
      sample();
      if (m_valid[1]) begin
        found = 1'b1;
        chk("post_reset_head", int'(m_data[1]), 8'hA0);
      end
      advance();
    end
    chk("post_reset_valid_seen", int'(found), 1);
    for (int c = 0; c < 10; c++) begin
      sample();
      advance();
    end
    chk("post_reset_count", n_consumed[1], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
